// File: rtl/rca_32.sv
// rca_32: 32-bit unsigned ripple-carry adder with a registered result.
// The carry ripples bit-serially through eight chained 4-bit blocks of
// full-adder cells. No lookahead logic and no "+" operator in the core,
// so the structure stays comparable against other adder architectures.

// Rca32FullAdder: single-bit full-adder cell.
module Rca32FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

// Rca32Block4: four full-adder cells with the carry chained LSB to MSB.
module Rca32Block4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co
);

  logic [4:0] w_carry;

  assign w_carry[0] = i_ci;
  assign o_co       = w_carry[4];

  for (genvar gBit = 0; gBit < 4; gBit++) begin : gCell
    Rca32FullAdder uCell (
      .i_a  (i_a[gBit]),
      .i_b  (i_b[gBit]),
      .i_ci (w_carry[gBit]),
      .o_s  (o_s[gBit]),
      .o_co (w_carry[gBit+1])
    );
  end

endmodule

// rca_32: eight ripple blocks chained, result captured in one register stage.
module rca_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        cin,
  output logic [31:0] S,
  output logic        cout
);

  logic [8:0]  w_blockCarry;
  logic [31:0] w_sum;
  logic [31:0] r_sum;
  logic        r_cout;

  assign w_blockCarry[0] = cin;

  for (genvar gBlk = 0; gBlk < 8; gBlk++) begin : gBlock
    Rca32Block4 uBlock (
      .i_a  (A[gBlk*4 +: 4]),
      .i_b  (B[gBlk*4 +: 4]),
      .i_ci (w_blockCarry[gBlk]),
      .o_s  (w_sum[gBlk*4 +: 4]),
      .o_co (w_blockCarry[gBlk+1])
    );
  end

  // Capture the rippled sum and final carry; reset clears both immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= 32'd0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_blockCarry[8];
    end
  end

  assign S    = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_rca_32.sv
// tb_rca_32: directed and randomized checks of rca_32 against a plain
// 33-bit arithmetic reference, including asynchronous reset behaviour.
module tb_rca_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A;
  logic [31:0] B;
  logic        cin;
  logic [31:0] S;
  logic        cout;

  int checkCount;
  int passCount;
  int failCount;

  // Value the registered outputs should currently show.
  logic [32:0] expNow;

  rca_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .S     (S),
    .cout  (cout)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: exact unsigned sum widened to 33 bits.
  function automatic logic [32:0] refSum(input logic [31:0] a, input logic [31:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  // Compare {cout,S} against the expected 33-bit value.
  task automatic checkOutput(input string tag, input logic [32:0] expected);
    logic [32:0] observed;
    observed = {cout, S};
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed cout=%0b S=%08h, expected cout=%0b S=%08h",
             tag, observed[32], observed[31:0], expected[32], expected[31:0]);
    end
  endtask

  // Drive one operation just after an edge: outputs must hold until the next
  // edge, then show exactly this operation's result.
  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic c,
                               input logic [32:0] expected);
    A   = a;
    B   = b;
    cin = c;
    #1;
    checkOutput({tag, "_hold"}, expNow);
    @(posedge clk);
    #1;
    checkOutput(tag, expected);
    expNow = expected;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;

    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    expNow     = 33'd0;

    rst_n = 1'b0;
    A     = 32'hFFFF_FFFF;
    B     = 32'hFFFF_FFFF;
    cin   = 1'b1;
    #1;
    checkOutput("reset_immediate", 33'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_edge1", 33'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_edge2", 33'd0);

    rst_n = 1'b1;
    applyStimulus("release_all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                  33'h1_FFFF_FFFF);

    applyStimulus("max_range", 32'd4294967290, 32'd4294967294, 1'b0,
                  {1'b1, 32'd4294967288});
    applyStimulus("full_ripple", 32'd1, 32'd4294967295, 1'b0,
                  {1'b1, 32'd0});
    applyStimulus("cin_small", 32'd1005, 32'd69, 1'b1, {1'b0, 32'd1075});
    applyStimulus("cin_large", 32'd151242, 32'd53831224, 1'b1,
                  {1'b0, 32'd53982467});
    applyStimulus("plain_add", 32'd501, 32'd5002423, 1'b0,
                  {1'b0, 32'd5002924});
    applyStimulus("zero_add", 32'd0, 32'd0, 1'b0, 33'd0);
    applyStimulus("cin_only", 32'd0, 32'd0, 1'b1, 33'd1);

    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_mid", 33'd0);
        #1;
        rst_n  = 1'b1;
        expNow = 33'd0;
      end
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      applyStimulus("random", ra, rb, rc, refSum(ra, rb, rc));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
